incline_integrator: RTL and testbench

//  Sensor-fusion stage producing the 13-bit signed incline consumed by incline_sat.

---
 rtl/incline_pkg.sv | 11 +
 rtl/incline_integrator.sv | 109 ++++++++++
 tb/tb_incline_integrator.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/incline_pkg.sv
// Shared widths and types for the incline fusion path.
package incline_pkg;
  localparam int INCL_W       = 13;
  localparam int RATE_W       = 16;
  localparam int INT_W        = 27;
  localparam int ACC_SLICE_HI = 25;
  localparam int ACC_SLICE_LO = 13;

  typedef logic signed [INCL_W-1:0] incl_t;
  typedef logic signed [RATE_W-1:0] rate_t;
endpackage

// File: rtl/incline_integrator.sv
// Complementary-filter incline: integrates offset-corrected roll rate and leaks the
// integrator toward the accelerometer-derived incline by a fixed step per sample.
module incline_integrator
  import incline_pkg::*;
#(
  parameter logic signed [15:0] ROLL_OFFSET    = 16'sh0050,
  parameter logic signed [15:0] AY_OFFSET      = 16'sh0000,
  parameter logic [9:0]         ACC_GAIN       = 10'd327,
  parameter logic [10:0]        FUSION_STEP    = 11'd1024,
  parameter logic [8:0]         SETTLE_SAMPLES = 9'd256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld,
  input  logic [RATE_W-1:0] roll_rt,
  input  logic [RATE_W-1:0] ay,
  output logic [INCL_W-1:0] incline,
  output logic              incline_vld,
  output logic              incline_rdy
);

  localparam int COMP_W = RATE_W + 1;
  localparam int PROD_W = 28;
  localparam int SUM_W  = INT_W + 2;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-INT_W+1){1'b0}}, {(INT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-INT_W+1){1'b1}}, {(INT_W-1){1'b0}}};

  function automatic logic signed [INT_W-1:0] sat_int(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[INT_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[INT_W-1:0];
    else                  return v[INT_W-1:0];
  endfunction

  rate_t                      roll_s, ay_s;
  logic signed [COMP_W-1:0]   roll_comp, ay_comp;
  logic signed [PROD_W-1:0]   acc_prod;
  logic                       unused_prod_bits;

  logic signed [COMP_W-1:0]   roll_comp_p1_d, roll_comp_p1_q;
  incl_t                      incl_acc_p1_d, incl_acc_p1_q;
  logic                       vld_p1_d, vld_p1_q;

  incl_t                      incline_s;
  logic signed [SUM_W-1:0]    fusion, step_s, sum;
  logic signed [INT_W-1:0]    roll_int_d, roll_int_q;
  logic                       incline_vld_d, incline_vld_q;
  logic [8:0]                 settle_cnt_d, settle_cnt_q;

  // ---- stage 1: offset correction and accelerometer scaling ----
  always_comb begin
    roll_s    = $signed(roll_rt);
    ay_s      = $signed(ay);
    roll_comp = COMP_W'(roll_s) - COMP_W'(ROLL_OFFSET);
    ay_comp   = COMP_W'(ay_s) - COMP_W'(AY_OFFSET);
    acc_prod  = PROD_W'(ay_comp) * PROD_W'($signed({1'b0, ACC_GAIN}));

    roll_comp_p1_d = roll_comp_p1_q;
    incl_acc_p1_d  = incl_acc_p1_q;
    vld_p1_d       = vld;
    if (vld) begin
      roll_comp_p1_d = roll_comp;
      incl_acc_p1_d  = acc_prod[ACC_SLICE_HI:ACC_SLICE_LO];
    end
  end

  assign unused_prod_bits = ^{acc_prod[PROD_W-1:ACC_SLICE_HI+1], acc_prod[ACC_SLICE_LO-1:0]};

  // ---- stage 2: fusion correction, integration with saturation ----
  always_comb begin
    incline_s = roll_int_q[INT_W-1:INT_W-INCL_W];
    step_s    = $signed(SUM_W'(FUSION_STEP));
    fusion    = '0;
    // Compare against the incline currently visible, before this update lands.
    if (incl_acc_p1_q > incline_s)      fusion = step_s;
    else if (incl_acc_p1_q < incline_s) fusion = -step_s;
    sum = SUM_W'(roll_int_q) - SUM_W'(roll_comp_p1_q) + fusion;

    roll_int_d    = roll_int_q;
    incline_vld_d = vld_p1_q;
    settle_cnt_d  = settle_cnt_q;
    if (vld_p1_q) begin
      roll_int_d = sat_int(sum);
      if (settle_cnt_q != SETTLE_SAMPLES) settle_cnt_d = settle_cnt_q + 9'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      roll_comp_p1_q <= '0;
      incl_acc_p1_q  <= '0;
      vld_p1_q       <= 1'b0;
      roll_int_q     <= '0;
      incline_vld_q  <= 1'b0;
      settle_cnt_q   <= '0;
    end else begin
      roll_comp_p1_q <= roll_comp_p1_d;
      incl_acc_p1_q  <= incl_acc_p1_d;
      vld_p1_q       <= vld_p1_d;
      roll_int_q     <= roll_int_d;
      incline_vld_q  <= incline_vld_d;
      settle_cnt_q   <= settle_cnt_d;
    end
  end

  assign incline     = incline_s;
  assign incline_vld = incline_vld_q;
  assign incline_rdy = (settle_cnt_q == SETTLE_SAMPLES);

endmodule

// File: tb/tb_incline_integrator.sv
// Directed bench for incline_integrator with hand-computed expected incline values.
module tb_incline_integrator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [15:0] roll_rt = '0;
  logic [15:0] ay = '0;
  logic [12:0] incline;
  logic        incline_vld;
  logic        incline_rdy;

  int n_chk  = 0;
  int n_pass = 0;

  incline_integrator dut (
    .clk(clk), .rst(rst), .vld(vld), .roll_rt(roll_rt), .ay(ay),
    .incline(incline), .incline_vld(incline_vld), .incline_rdy(incline_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int incl_i();
    return int'($signed(incline));
  endfunction

  task automatic do_reset();
    vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One isolated sample; returns at the negedge where its incline_vld is visible.
  task automatic step(input int r, input int a);
    vld = 1'b1;
    roll_rt = 16'(r);
    ay = 16'(a);
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int bad, miss, prev, wraps, vcnt;
    int exp_incl[8];
    bit exp_v[8];

    // Reset state
    do_reset();
    check("rst_incline", incl_i(), 0);
    check("rst_vld", int'(incline_vld), 0);
    check("rst_rdy", int'(incline_rdy), 0);

    // 1: reset one clock after a sample is taken
    vld = 1'b1; roll_rt = 16'(80 - 16384); ay = '0;
    @(negedge clk);
    vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (incline_vld) vcnt++;
    end
    check("midrst_vld_cnt", vcnt, 0);
    check("midrst_incline", incl_i(), 0);
    check("midrst_rdy", int'(incline_rdy), 0);

    // 2: zero-rate input, settle counter
    do_reset();
    bad = 0; miss = 0;
    for (int i = 1; i <= 300; i++) begin
      step(80, 0);
      if (incl_i() != 0) bad++;
      if (!incline_vld) miss++;
      if (i == 255) check("rdy_before_256", int'(incline_rdy), 0);
      if (i == 256) check("rdy_at_256", int'(incline_rdy), 1);
    end
    check("zero_incline_nonzero", bad, 0);
    check("zero_vld_missing", miss, 0);
    check("zero_rdy_hold", int'(incline_rdy), 1);

    // 3: rate step, 16384 per sample minus fusion pull toward 0
    do_reset();
    step(80 - 16384, 0);
    check("rate_s1_vld", int'(incline_vld), 1);
    check("rate_s1_incline", incl_i(), 1);
    step(80 - 16384, 0);
    check("rate_s2_incline", incl_i(), 1);
    step(80 - 16384, 0);
    check("rate_s3_incline", incl_i(), 2);
    @(negedge clk);
    check("rate_vld_single", int'(incline_vld), 0);

    // 4: fusion toward accel incline 327, +1024 per sample
    do_reset();
    for (int i = 0; i < 15; i++) step(80, 8192);
    check("fus_15", incl_i(), 0);
    step(80, 8192);
    check("fus_16", incl_i(), 1);
    for (int i = 16; i < 5400; i++) step(80, 8192);
    check("fus_converged", int'(incl_i() == 326 || incl_i() == 327), 1);
    check("fus_rdy", int'(incline_rdy), 1);

    // 5: saturation both directions
    do_reset();
    prev = 0; wraps = 0;
    for (int i = 0; i < 2200; i++) begin
      step(-32768, 0);
      if (incl_i() < prev) wraps++;
      prev = incl_i();
    end
    check("satp_incline", incl_i(), 4095);
    check("satp_nowrap", wraps, 0);
    do_reset();
    prev = 0; wraps = 0;
    for (int i = 0; i < 2200; i++) begin
      step(32767, 0);
      if (incl_i() > prev) wraps++;
      prev = incl_i();
    end
    check("satn_incline", incl_i(), -4096);
    check("satn_nowrap", wraps, 0);

    // 6: four back-to-back samples
    do_reset();
    exp_v = '{0, 0, 1, 1, 1, 1, 0, 0};
    exp_incl = '{0, 0, 1, 1, 2, 3, 3, 3};
    roll_rt = 16'(80 - 16384); ay = '0;
    vld = 1'b1;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (k == 4) vld = 1'b0;
      check($sformatf("b2b_vld_%0d", k), int'(incline_vld), int'(exp_v[k]));
      if (exp_v[k]) check($sformatf("b2b_incl_%0d", k), incl_i(), exp_incl[k]);
    end
    check("b2b_final", incl_i(), 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
